axis_counter_chk: RTL and testbench

- AXI-Stream sink that accepts a counting-pattern stream and checks it beat by beat.
- Expected beat data is {frame_id[15:0], beat_idx[15:0]}. Expected framing is one TLAST every FRAME_BEATS beats.
- Drives a programmable TREADY backpressure pattern and keeps saturating status counters.
- Sits at the output of FIFO/DUT-under-test paths in simulation benches; the pattern producer sits at the other end.

---
 rtl/axis_chk_pkg.sv | 34 +++
 rtl/axis_chk_sat_cnt.sv | 47 ++++
 rtl/axis_counter_chk.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_counter_chk.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream counting-pattern checker.
//   - FSM state encoding (ST_RUN, ST_HALT)
//   - Counting-pattern field widths and the packed beat word {frame_id, beat_idx}
//   - Saturating-increment helper used by the status counters
package axis_chk_pkg;

  localparam int unsigned FRAME_ID_W = 16;
  localparam int unsigned BEAT_IDX_W = 16;
  localparam int unsigned PAT_W      = FRAME_ID_W + BEAT_IDX_W;
  localparam int unsigned IDX_W      = 32;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_MAX_W  = 64;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chk_state_e;

  // Expected beat word as produced by the pattern source.
  typedef struct packed {
    logic [FRAME_ID_W-1:0] frame_id;
    logic [BEAT_IDX_W-1:0] beat_idx;
  } pat_word_t;

  // Increment val, holding at max_val once reached.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] val,
    input logic [SAT_MAX_W-1:0] max_val
  );
    return (val >= max_val) ? max_val : (val + SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/axis_chk_sat_cnt.sv
// Saturating status counter with synchronous reset and clear.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - synchronous clear to zero (same effect as rst)
//   inc  - increment by one, holding at all-ones
//   cnt  - registered count (CNT_W bits, CNT_W <= 64)
module axis_chk_sat_cnt
  import axis_chk_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [SAT_MAX_W-1:0] CNT_MAX =
    (CNT_W >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}}
                         : ((SAT_MAX_W'(1) << CNT_W) - SAT_MAX_W'(1));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/axis_counter_chk.sv
// AXI-Stream sink that checks a counting-pattern stream beat by beat.
// Expected data is {frame_id[15:0], beat_idx[15:0]} (zero-extended/truncated
// to DATA_W); expected framing is one TLAST every FRAME_BEATS beats. TREADY
// follows a rotating READY_PATTERN mask; saturating counters track results.
// Optional feature macro: AXIS_COUNTER_CHK_FIRST_ERR_EN adds first-error
// capture outputs (first_err_valid/exp/act/beat).
// Ports:
//   aclk, areset           - clock, synchronous active-high reset
//   s_axis_*               - AXI-Stream slave (tuser ignored)
//   clear_stats            - synchronous clear of checker state and counters
//   stat_beats/frames      - accepted beats / accepted TLAST beats
//   stat_err_data/last/keep- beats with data / TLAST / TKEEP mismatch
//   err_flag               - sticky error indicator
//   halted                 - checker stopped after an error (HALT_ON_ERR=1)
module axis_counter_chk
  import axis_chk_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned KEEP_W        = DATA_W / 8,
  parameter int unsigned USER_W        = 1,
  parameter int unsigned FRAME_BEATS   = 8,
  parameter logic [31:0] READY_PATTERN = 32'hFFFF_FFFF,
  parameter int unsigned HALT_ON_ERR   = 0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  stat_beats,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_err_data,
  output logic [CNT_W-1:0]  stat_err_last,
  output logic [CNT_W-1:0]  stat_err_keep,
  output logic              err_flag,
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
  output logic              first_err_valid,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic [CNT_W-1:0]  first_err_beat,
`endif
  output logic              halted
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(FRAME_BEATS - 1);

  chk_state_e        state_q, state_d;
  logic [31:0]       mask_q, mask_d;
  logic              tready_q, tready_d;
  logic [IDX_W-1:0]  exp_frame_q, exp_frame_d;
  logic [IDX_W-1:0]  exp_beat_q, exp_beat_d;
  logic              err_flag_q, err_flag_d;

  pat_word_t         exp_pat_c;
  logic [PAT_W-1:0]  exp_word_c;
  logic [DATA_W-1:0] exp_data_c;
  logic              exp_last_c;
  logic              accept_c;
  logic              beat_ok_c;
  logic              err_data_c;
  logic              err_last_c;
  logic              err_keep_c;
  logic              any_err_c;

  logic              unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // Expected beat derived from the tracked frame/beat indices.
  assign exp_pat_c.frame_id = exp_frame_q[FRAME_ID_W-1:0];
  assign exp_pat_c.beat_idx = exp_beat_q[BEAT_IDX_W-1:0];
  assign exp_word_c         = exp_pat_c;
  assign exp_data_c         = DATA_W'(exp_word_c);
  assign exp_last_c         = (exp_beat_q == LAST_BEAT);

  // A beat accepted during clear_stats is dropped entirely.
  assign accept_c   = s_axis_tvalid && tready_q;
  assign beat_ok_c  = accept_c && !clear_stats;

  assign err_data_c = (s_axis_tdata != exp_data_c);
  assign err_last_c = (s_axis_tlast != exp_last_c);
  assign err_keep_c = (s_axis_tkeep != {KEEP_W{1'b1}});
  assign any_err_c  = err_data_c || err_last_c || err_keep_c;

  // Checker next-state: framing tracker, sticky error, halt FSM, ready mask.
  always_comb begin
    state_d     = state_q;
    mask_d      = {mask_q[0], mask_q[31:1]};
    exp_frame_d = exp_frame_q;
    exp_beat_d  = exp_beat_q;
    err_flag_d  = err_flag_q;
    tready_d    = tready_q;

    if (clear_stats) begin
      state_d     = ST_RUN;
      mask_d      = READY_PATTERN;
      exp_frame_d = '0;
      exp_beat_d  = '0;
      err_flag_d  = 1'b0;
    end else if (beat_ok_c) begin
      // Follow observed framing so a bad TLAST resyncs the tracker.
      if (s_axis_tlast) begin
        exp_beat_d  = '0;
        exp_frame_d = exp_frame_q + IDX_W'(1);
      end else begin
        exp_beat_d  = exp_beat_q + IDX_W'(1);
      end
      if (any_err_c) begin
        err_flag_d = 1'b1;
        if (HALT_ON_ERR != 0) begin
          state_d = ST_HALT;
        end
      end
    end

    // Ready holds through a clear; otherwise it drops as soon as we halt.
    if (!clear_stats) begin
      tready_d = (state_d == ST_RUN) && mask_q[0];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_RUN;
      mask_q      <= READY_PATTERN;
      tready_q    <= 1'b0;
      exp_frame_q <= '0;
      exp_beat_q  <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      tready_q    <= tready_d;
      exp_frame_q <= exp_frame_d;
      exp_beat_q  <= exp_beat_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign err_flag      = err_flag_q;
  assign halted        = (state_q == ST_HALT);

  // Status counters.
  axis_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt_beats (
    .clk (aclk),
    .rst (areset),
    .clr (clear_stats),
    .inc (beat_ok_c),
    .cnt (stat_beats)
  );

  axis_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt_frames (
    .clk (aclk),
    .rst (areset),
    .clr (clear_stats),
    .inc (beat_ok_c && s_axis_tlast),
    .cnt (stat_frames)
  );

  axis_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt_err_data (
    .clk (aclk),
    .rst (areset),
    .clr (clear_stats),
    .inc (beat_ok_c && err_data_c),
    .cnt (stat_err_data)
  );

  axis_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt_err_last (
    .clk (aclk),
    .rst (areset),
    .clr (clear_stats),
    .inc (beat_ok_c && err_last_c),
    .cnt (stat_err_last)
  );

  axis_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt_err_keep (
    .clk (aclk),
    .rst (areset),
    .clr (clear_stats),
    .inc (beat_ok_c && err_keep_c),
    .cnt (stat_err_keep)
  );

`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
  logic              fe_valid_q, fe_valid_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0] fe_act_q, fe_act_d;
  logic [CNT_W-1:0]  fe_beat_q, fe_beat_d;

  // Capture the first erroring beat; stat_beats is still the pre-increment count.
  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_exp_d   = fe_exp_q;
    fe_act_d   = fe_act_q;
    fe_beat_d  = fe_beat_q;
    if (clear_stats) begin
      fe_valid_d = 1'b0;
      fe_exp_d   = '0;
      fe_act_d   = '0;
      fe_beat_d  = '0;
    end else if (beat_ok_c && any_err_c && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_exp_d   = exp_data_c;
      fe_act_d   = s_axis_tdata;
      fe_beat_d  = stat_beats;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      fe_valid_q <= 1'b0;
      fe_exp_q   <= '0;
      fe_act_q   <= '0;
      fe_beat_q  <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_exp_q   <= fe_exp_d;
      fe_act_q   <= fe_act_d;
      fe_beat_q  <= fe_beat_d;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_act   = fe_act_q;
  assign first_err_beat  = fe_beat_q;
`endif

endmodule

// File: tb/tb_axis_counter_chk.sv
// Directed bench for axis_counter_chk. Three instances share clock/reset:
//   0: all-ones ready, HALT_ON_ERR=0
//   1: 0x5555_5555 ready, HALT_ON_ERR=1
//   2: all-ones ready, CNT_W=3 (counter saturation)
module tb_axis_counter_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic        tvalid [3];
  logic [31:0] tdata  [3];
  logic [3:0]  tkeep  [3];
  logic        tlast  [3];
  logic        tuser  [3];
  logic        clear  [3];
  logic        tready [3];
  logic        err_flag [3];
  logic        halted   [3];

  logic [31:0] beats  [2];
  logic [31:0] frames [2];
  logic [31:0] e_data [2];
  logic [31:0] e_last [2];
  logic [31:0] e_keep [2];
  logic [2:0]  c_beats, c_frames, c_edata, c_elast, c_ekeep;

`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
  logic        fe_valid [3];
  logic [31:0] fe_exp   [3];
  logic [31:0] fe_act   [3];
  logic [31:0] fe_beat  [2];
  logic [2:0]  c_fe_beat;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axis_counter_chk u_dut_a (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tvalid (tvalid[0]),
    .s_axis_tready (tready[0]),
    .s_axis_tdata  (tdata[0]),
    .s_axis_tkeep  (tkeep[0]),
    .s_axis_tlast  (tlast[0]),
    .s_axis_tuser  (tuser[0]),
    .clear_stats   (clear[0]),
    .stat_beats    (beats[0]),
    .stat_frames   (frames[0]),
    .stat_err_data (e_data[0]),
    .stat_err_last (e_last[0]),
    .stat_err_keep (e_keep[0]),
    .err_flag      (err_flag[0]),
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    .first_err_valid (fe_valid[0]),
    .first_err_exp   (fe_exp[0]),
    .first_err_act   (fe_act[0]),
    .first_err_beat  (fe_beat[0]),
`endif
    .halted        (halted[0])
  );

  axis_counter_chk #(
    .READY_PATTERN (32'h5555_5555),
    .HALT_ON_ERR   (1)
  ) u_dut_b (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tvalid (tvalid[1]),
    .s_axis_tready (tready[1]),
    .s_axis_tdata  (tdata[1]),
    .s_axis_tkeep  (tkeep[1]),
    .s_axis_tlast  (tlast[1]),
    .s_axis_tuser  (tuser[1]),
    .clear_stats   (clear[1]),
    .stat_beats    (beats[1]),
    .stat_frames   (frames[1]),
    .stat_err_data (e_data[1]),
    .stat_err_last (e_last[1]),
    .stat_err_keep (e_keep[1]),
    .err_flag      (err_flag[1]),
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    .first_err_valid (fe_valid[1]),
    .first_err_exp   (fe_exp[1]),
    .first_err_act   (fe_act[1]),
    .first_err_beat  (fe_beat[1]),
`endif
    .halted        (halted[1])
  );

  axis_counter_chk #(
    .CNT_W (3)
  ) u_dut_c (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tvalid (tvalid[2]),
    .s_axis_tready (tready[2]),
    .s_axis_tdata  (tdata[2]),
    .s_axis_tkeep  (tkeep[2]),
    .s_axis_tlast  (tlast[2]),
    .s_axis_tuser  (tuser[2]),
    .clear_stats   (clear[2]),
    .stat_beats    (c_beats),
    .stat_frames   (c_frames),
    .stat_err_data (c_edata),
    .stat_err_last (c_elast),
    .stat_err_keep (c_ekeep),
    .err_flag      (err_flag[2]),
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    .first_err_valid (fe_valid[2]),
    .first_err_exp   (fe_exp[2]),
    .first_err_act   (fe_act[2]),
    .first_err_beat  (c_fe_beat),
`endif
    .halted        (halted[2])
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int f, input int b);
    return {16'(f), 16'(b)};
  endfunction

  // Present one beat and hold it until the handshake edge has passed.
  task automatic send_beat(input int d, input logic [31:0] data, input logic last,
                           input logic [3:0] keep);
    int n;
    n = 0;
    @(negedge clk);
    tvalid[d] = 1'b1;
    tdata[d]  = data;
    tlast[d]  = last;
    tkeep[d]  = keep;
    while (tready[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_val($sformatf("d%0d_ready_wait", d), 64'(n), 64'(0));
    @(posedge clk);
  endtask

  task automatic send_frame(input int d, input int f, input int n_beats);
    for (int b = 0; b < n_beats; b++) begin
      send_beat(d, pat(f, b), (b == n_beats - 1), 4'hF);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
  endtask

  task automatic do_clear(input int d);
    @(negedge clk);
    tvalid[d] = 1'b0;
    clear[d]  = 1'b1;
    @(negedge clk);
    clear[d]  = 1'b0;
  endtask

  task automatic check_stats(input int d, input int eb, input int ef, input int ed,
                             input int el, input int ek, input logic ef_flag);
    check_val($sformatf("d%0d_beats", d),    beats[d],    64'(eb));
    check_val($sformatf("d%0d_frames", d),   frames[d],   64'(ef));
    check_val($sformatf("d%0d_err_data", d), e_data[d],   64'(ed));
    check_val($sformatf("d%0d_err_last", d), e_last[d],   64'(el));
    check_val($sformatf("d%0d_err_keep", d), e_keep[d],   64'(ek));
    check_val($sformatf("d%0d_err_flag", d), err_flag[d], 64'(ef_flag));
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("%s_d%0d_tready", tag, d), tready[d], 0);
      check_val($sformatf("%s_d%0d_halted", tag, d), halted[d], 0);
      check_stats(d, 0, 0, 0, 0, 0, 1'b0);
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
      check_val($sformatf("%s_d%0d_fe_valid", tag, d), fe_valid[d], 0);
      check_val($sformatf("%s_d%0d_fe_exp", tag, d),   fe_exp[d],   0);
      check_val($sformatf("%s_d%0d_fe_act", tag, d),   fe_act[d],   0);
      check_val($sformatf("%s_d%0d_fe_beat", tag, d),  fe_beat[d],  0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    areset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tvalid[d] = 1'b0;
      tdata[d]  = '0;
      tkeep[d]  = 4'hF;
      tlast[d]  = 1'b0;
      tuser[d]  = 1'b0;
      clear[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state, including the small-counter instance.
    check_reset_state("rst");
    check_val("rst_c_beats", {c_beats, c_frames, c_edata, c_elast, c_ekeep}, 0);
    check_val("rst_c_flags", {tready[2], err_flag[2], halted[2]}, 0);
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    check_val("rst_c_fe", {fe_valid[2], fe_exp[2], c_fe_beat}, 0);
    check_val("rst_c_fe_act", fe_act[2], 0);
`endif

    // First ready one cycle after reset release; 0x5555 mask alternates 1/0.
    areset = 1'b0;
    check_val("ready_release_a", tready[0], 0);
    @(negedge clk);
    check_val("ready_first_a", tready[0], 1);
    check_val("ready_alt_b0", tready[1], 1);
    @(negedge clk);
    check_val("ready_alt_b1", tready[1], 0);
    @(negedge clk);
    check_val("ready_alt_b2", tready[1], 1);
    @(negedge clk);
    check_val("ready_alt_b3", tready[1], 0);

    // Three clean frames, full throughput.
    for (int f = 0; f < 3; f++) send_frame(0, f, 8);
    idle(0);
    check_stats(0, 24, 3, 0, 0, 0, 1'b0);

    // Saturation on the 3-bit-counter instance: 10 clean beats.
    for (int i = 0; i < 10; i++) send_beat(2, pat(i / 8, i % 8), (i % 8 == 7), 4'hF);
    idle(2);
    check_val("sat_beats", c_beats, 7);
    check_val("sat_frames", c_frames, 1);
    check_val("sat_errs", {c_edata, c_elast, c_ekeep}, 0);

    // Same stream through alternating ready with valid held.
    for (int f = 0; f < 3; f++) send_frame(1, f, 8);
    idle(1);
    check_stats(1, 24, 3, 0, 0, 0, 1'b0);
    check_val("b_halted_clean", halted[1], 0);

    // Beat presented during clear_stats is dropped.
    @(negedge clk);
    tvalid[0] = 1'b1;
    tdata[0]  = 32'hDEAD_BEEF;
    tlast[0]  = 1'b1;
    tkeep[0]  = 4'h0;
    clear[0]  = 1'b1;
    @(negedge clk);
    clear[0]  = 1'b0;
    tvalid[0] = 1'b0;
    tlast[0]  = 1'b0;
    check_stats(0, 0, 0, 0, 0, 0, 1'b0);

    // Data error at frame 1 beat 5.
    send_frame(0, 0, 8);
    for (int b = 0; b < 8; b++) begin
      send_beat(0, (b == 5) ? 32'hDEAD_BEEF : pat(1, b), (b == 7), 4'hF);
    end
    idle(0);
    check_stats(0, 16, 2, 1, 0, 0, 1'b1);
    check_val("a_not_halted", halted[0], 0);
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    check_val("fe_valid_data", fe_valid[0], 1);
    check_val("fe_exp_data",   fe_exp[0],   32'h0001_0005);
    check_val("fe_act_data",   fe_act[0],   32'hDEAD_BEEF);
    check_val("fe_beat_data",  fe_beat[0],  13);
`endif

    // Early TLAST on frame 0 beat 3, then resynced frame 1.
    do_clear(0);
    send_frame(0, 0, 4);
    send_frame(0, 1, 8);
    idle(0);
    check_stats(0, 12, 2, 0, 1, 0, 1'b1);
`ifdef AXIS_COUNTER_CHK_FIRST_ERR_EN
    check_val("fe_exp_last",  fe_exp[0],  32'h0000_0003);
    check_val("fe_act_last",  fe_act[0],  32'h0000_0003);
    check_val("fe_beat_last", fe_beat[0], 3);
`endif

    // HALT_ON_ERR: bad TKEEP on beat 2 stops the sink until clear.
    do_clear(1);
    send_beat(1, pat(0, 0), 1'b0, 4'hF);
    send_beat(1, pat(0, 1), 1'b0, 4'hF);
    send_beat(1, pat(0, 2), 1'b0, 4'h7);
    @(negedge clk);
    check_val("halt_ready_next", tready[1], 0);
    check_val("halt_flag", halted[1], 1);
    tdata[1] = pat(0, 3);
    tkeep[1] = 4'hF;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tready[1] !== 1'b0) seen++;
    end
    check_val("halt_ready_held", 64'(seen), 0);
    check_stats(1, 3, 0, 0, 0, 1, 1'b1);
    do_clear(1);
    check_stats(1, 0, 0, 0, 0, 0, 1'b0);
    check_val("clear_unhalt", halted[1], 0);
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      @(negedge clk);
      if (tready[1] === 1'b1) seen = 1;
    end
    check_val("ready_resume", 64'(seen), 1);
    send_beat(1, pat(0, 0), 1'b0, 4'hF);
    idle(1);
    check_stats(1, 1, 0, 0, 0, 0, 1'b0);

    // Reset mid-frame at frame 2 beat 4, then a fresh stream.
    do_clear(0);
    send_frame(0, 0, 8);
    send_frame(0, 1, 8);
    for (int b = 0; b < 4; b++) send_beat(0, pat(2, b), 1'b0, 4'hF);
    @(negedge clk);
    tdata[0] = pat(2, 4);
    areset   = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    areset    = 1'b0;
    tvalid[0] = 1'b0;
    send_frame(0, 0, 8);
    idle(0);
    check_stats(0, 8, 1, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
